// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source half of a four-phase req/ack CDC handshake.
// Holds a word on data_out while req_out is raised; ack_in is synchronized here.
module cdc_hs_tx #(
    parameter int   DATA_W      = 8,
    parameter int   CNT_W       = 8,
    parameter int   TIMEOUT_CYC = 64,
    parameter logic ACK_RST_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              req_out,
    output logic [DATA_W-1:0] data_out,
    input  logic              ack_in,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              timeout_err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ_HI,
        ACK_LO
    } state_t;

    localparam int               TMO_W   = 16;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic             ack_meta;
    logic             ack_s;
    logic [TMO_W-1:0] tmo_cnt;
    logic             waiting;
    logic             tmo_hit;

    // a late ack from a previous transfer blocks new accepts
    assign in_ready = (state == IDLE) && !ack_s;

    // still waiting for the awaited ack_s level in the current phase
    assign waiting = ((state == REQ_HI) && !ack_s) ||
                     ((state == ACK_LO) && ack_s);

    // the wait counter is about to reach the limit
    assign tmo_hit = waiting && (tmo_cnt == (TMO_MAX - TMO_ONE));

    // two-flop synchronizer for the asynchronous acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta <= ACK_RST_VAL;
            ack_s    <= ACK_RST_VAL;
        end else begin
            ack_meta <= ack_in;
            ack_s    <= ack_meta;
        end
    end

    // handshake FSM with registered req/data/busy/count and wait timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_out  <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
            xfer_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_out <= in_data;
                        req_out  <= 1'b1;
                        busy     <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= REQ_HI;
                    end
                end
                REQ_HI: begin
                    if (ack_s) begin
                        req_out <= 1'b0;
                        tmo_cnt <= '0;
                        state   <= ACK_LO;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                ACK_LO: begin
                    if (!ack_s) begin
                        busy     <= 1'b0;
                        xfer_cnt <= xfer_cnt + CNT_ONE;
                        state    <= IDLE;
                    end else if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + TMO_ONE;
                    end
                end
                default: begin
                    req_out <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // sticky stall flag; a new stall beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (tmo_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: directed bench for the CDC handshake transmitter.
// Bench acts as the remote receiver and drives ack_in procedurally.
module tb_cdc_hs_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       req_out;
    logic [7:0] data_out;
    logic       ack_in;
    logic       busy;
    logic [3:0] xfer_cnt;
    logic       timeout_err;
    logic       err_clr;

    int n_chk = 0;
    int n_err = 0;

    cdc_hs_tx #(
        .DATA_W      (8),
        .CNT_W       (4),
        .TIMEOUT_CYC (8),
        .ACK_RST_VAL (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .req_out     (req_out),
        .data_out    (data_out),
        .ack_in      (ack_in),
        .busy        (busy),
        .xfer_cnt    (xfer_cnt),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send(input logic [7:0] d, input logic hold,
                        input logic [7:0] nd);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        check("send_wait", 32'(n < 40), 1);
        tick();
        check("acc_req", req_out, 1);
        check("acc_data", data_out, d);
        in_valid = hold;
        in_data  = nd;
    endtask

    task automatic respond(input logic [7:0] d);
        logic stable = 1'b1;
        int   n      = 0;
        repeat (3) begin
            tick();
            if (data_out !== d) stable = 1'b0;
        end
        ack_in = 1'b1;
        while (req_out && n < 40) begin
            tick();
            n++;
            if (data_out !== d) stable = 1'b0;
        end
        check("req_fall", req_out, 0);
        repeat (3) begin
            tick();
            if (data_out !== d) stable = 1'b0;
        end
        ack_in = 1'b0;
        n      = 0;
        while (busy && n < 40) begin
            tick();
            n++;
            if (busy && data_out !== d) stable = 1'b0;
        end
        check("done_idle", busy, 0);
        check("hold_data", stable, 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        ack_in   = 1'b0;
        err_clr  = 1'b0;

        // reset state
        do_reset();
        check("rst_req", req_out, 0);
        check("rst_data", data_out, 0);
        check("rst_cnt", xfer_cnt, 0);
        check("rst_err", timeout_err, 0);
        check("rst_busy", busy, 0);
        check("rst_rdy", in_ready, 1);

        // single transfer with cycle-exact timing
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h5A;
        check("s_req", req_out, 1);
        check("s_data", data_out, 8'hA5);
        check("s_rdy", in_ready, 0);
        check("s_busy", busy, 1);
        repeat (3) tick();
        ack_in = 1'b1;
        tick();
        check("s_req_m", req_out, 1);
        tick();
        check("s_req_m1", req_out, 1);
        tick();
        check("s_req_m2", req_out, 0);
        check("s_data_lo", data_out, 8'hA5);
        repeat (3) tick();
        ack_in = 1'b0;
        tick();
        check("s_busy_k", busy, 1);
        tick();
        check("s_rdy_k1", in_ready, 0);
        check("s_cnt_k1", xfer_cnt, 0);
        tick();
        check("s_rdy_k2", in_ready, 1);
        check("s_busy_k2", busy, 0);
        check("s_cnt_k2", xfer_cnt, 1);
        check("s_data_k2", data_out, 8'hA5);

        // back-to-back with in_valid held high
        do_reset();
        send(8'h01, 1'b1, 8'h02);
        respond(8'h01);
        send(8'h02, 1'b1, 8'h03);
        respond(8'h02);
        send(8'h03, 1'b0, 8'h00);
        respond(8'h03);
        check("b2b_cnt", xfer_cnt, 3);
        check("b2b_data", data_out, 8'h03);

        // counter wrap on a 4-bit count
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send(8'(8'h10 + i), 1'b0, 8'h00);
            respond(8'(8'h10 + i));
            if (i == 15) check("wrap_16", xfer_cnt, 0);
        end
        check("wrap_17", xfer_cnt, 1);

        // timeout with simultaneous set/clear, then clear and finish
        do_reset();
        send(8'h3C, 1'b0, 8'h00);
        repeat (7) tick();
        check("to_pre", timeout_err, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_set", timeout_err, 1);
        check("to_req", req_out, 1);
        repeat (3) tick();
        check("to_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_clr", timeout_err, 0);
        repeat (4) tick();
        check("to_noreset", timeout_err, 0);
        check("to_req_hold", req_out, 1);
        respond(8'h3C);
        check("to_cnt", xfer_cnt, 1);
        check("to_err_end", timeout_err, 0);

        // reset in ACK_LO with ack still high
        do_reset();
        send(8'h77, 1'b0, 8'h00);
        ack_in = 1'b1;
        for (int n = 0; n < 40 && req_out; n++) tick();
        tick();
        check("mr_busy_pre", busy, 1);
        check("mr_req_pre", req_out, 0);
        rst = 1'b1;
        tick();
        check("mr_req", req_out, 0);
        check("mr_busy", busy, 0);
        check("mr_data", data_out, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("mr_rdy_a", in_ready, 0);
        repeat (3) tick();
        check("mr_rdy_b", in_ready, 0);
        ack_in = 1'b0;
        tick();
        check("mr_rdy_k", in_ready, 0);
        tick();
        check("mr_rdy_k1", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cdc_hs_tx.md
# cdc_hs_tx

Source-side (transmitter) half of a four-phase req/ack clock-domain-crossing handshake. Accepts a data word from local logic over a valid/ready interface and holds it stable on `data_out` while driving a glitch-free registered `req_out` to a remote domain. The remote receiver synchronizes `req_out`, captures `data_out`, and returns `ack_in` asynchronously. This block synchronizes `ack_in` internally with a two-flop synchronizer, completes the four-phase sequence, and counts transfers. It also flags a sticky timeout when the far side stalls.

## Interface
Parameters:
- `DATA_W`, default 8: width of the transferred word.
- `CNT_W`, default 8: width of the completed-transfer counter.
- `TIMEOUT_CYC`, default 64: cycles without the awaited `ack_s` edge before `timeout_err` sets; legal range 2..65535.
- `ACK_RST_VAL`, default 1'b0: reset value of both `ack_in` synchronizer stages.

Ports:
- `clk` input 1: the only clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: local word available.
- `in_data` input DATA_W: local word.
- `in_ready` output 1: block can accept a word.
- `req_out` output 1: handshake request to the remote domain; driven directly from a flop.
- `data_out` output DATA_W: held word to the remote domain; driven directly from a flop.
- `ack_in` input 1: asynchronous acknowledge from the remote domain.
- `busy` output 1: a handshake is in progress.
- `xfer_cnt` output CNT_W: number of completed handshakes.
- `timeout_err` output 1: sticky stall flag.
- `err_clr` input 1: clears `timeout_err`.

## Operation
- The block has one clock and one reset. Reset is synchronous and active-high. The clock port is `clk` and the reset port is `rst`.
- `ack_s` is the output of two flops in series sampling `ack_in`. The FSM uses only `ack_s` and never uses raw `ack_in`.
- FSM state IDLE: `in_ready`=1 and `busy`=0.
  - On `in_valid`&&`in_ready`, the block loads `data_out`<=`in_data`, sets `req_out`<=1, and moves to REQ_HI.
  - If `ack_s` is still 1 in IDLE, the block holds in IDLE with `in_ready`=0 until `ack_s`=0. This protects against a late ack from a prior transfer.
- FSM state REQ_HI: `req_out`=1, `busy`=1 and `in_ready`=0.
  - On `ack_s`=1, the block sets `req_out`<=0 and moves to ACK_LO.
- FSM state ACK_LO: `req_out`=0, `busy`=1 and `in_ready`=0.
  - On `ack_s`=0, the block moves to IDLE and increments `xfer_cnt`.
- `data_out` changes only on the accept edge. It stays stable from `req_out` rise until the return to IDLE.
- `xfer_cnt` wraps modulo 2^CNT_W. For example, with CNT_W=8, a count of 255 goes to 0.
- Timeout counter:
  - It clears on entry to REQ_HI and on entry to ACK_LO.
  - It increments each cycle spent in those states and saturates at TIMEOUT_CYC.
  - When it reaches TIMEOUT_CYC, `timeout_err`<=1.
  - The handshake is not aborted; the FSM keeps waiting.
- `err_clr` clears `timeout_err`. If a set and `err_clr` occur in the same cycle, the set wins.
- Reset values:
  - `req_out`=0, `data_out`=0, `busy`=0, `xfer_cnt`=0, `timeout_err`=0.
  - FSM state is IDLE.
  - Both synchronizer stages are ACK_RST_VAL.
  - `in_ready` follows the IDLE rule from the cycle after reset deasserts.
- Reset mid-handshake: on the reset edge, `req_out` drops to 0 and `data_out` goes to 0. The protocol on the far side must also be reset; this block does not re-sync.

## Timing
- Accept at edge N: `req_out`=1 and `data_out` is valid after edge N. `in_ready`=0 after edge N.
- `ack_in` rise sampled at edge M: `ack_s`=1 after edge M+1, and `req_out`=0 after edge M+2.
- `ack_in` fall sampled at edge K: `ack_s`=0 after edge K+1, state is IDLE after edge K+2, and `xfer_cnt` increments at edge K+2.
- At the IDLE edge (K+2), `in_ready`=1. The next accept can occur at edge K+3 at the earliest.
- `in_valid` held while `in_ready`=0 is ignored. Its data is not captured.
- `busy` equals (state != IDLE) and is registered with the state.
- A glitch on `ack_in` shorter than one clock period may be missed. A missed glitch does not corrupt state; the stall is reported by `timeout_err`.

## Test plan
- Reset behaviour: assert `rst` for 2 cycles with `ack_in`=0, then release. Require `req_out`=0, `data_out`=0, `xfer_cnt`=0, `timeout_err`=0, and `in_ready`=1.
- Single transfer: send `in_data`=8'hA5 with `in_valid` for one cycle. A bench responder raises `ack_in` 3 cycles after `req_out` rises and lowers it 3 cycles after `req_out` falls. Require `data_out`=A5 throughout, `req_out` to fall 2 cycles after `ack_in` rises, and `xfer_cnt`=1 with `in_ready`=1 2 cycles after `ack_in` falls.
- Back-to-back transfers: hold `in_valid` continuously with data sequence 01,02,03. Require three handshakes, `data_out` to change only on accept edges, and `xfer_cnt`=3.
- Counter wrap: with CNT_W=4, run 17 transfers. Require `xfer_cnt`=1.
- Timeout: with TIMEOUT_CYC=8, never raise `ack_in`. Require `timeout_err`=1 after 8 cycles in REQ_HI with `req_out` still 1. Then pulse `err_clr` and verify it clears. Then raise `ack_in` and require normal completion.
- Reset mid-handshake: assert `rst` while in ACK_LO with `ack_in`=1. Require `req_out`=0 and `busy`=0 after the edge. After release, with `ack_in` still 1, require `in_ready`=0 until `ack_s` falls.
